mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Multi-cycle signed 32x32 multiply and signed 32/32 divide engine.
- The combinational ALU handles ADD/SUB/logic/shift ops; MUL and DIV are issued here instead.
- Its registered 64-bit result {Chigh, Clow} feeds the datapath's Z-result path in place of the ALU result.
- Chigh/Clow follow the HI/LO convention: MUL gives the 64-bit product; DIV gives remainder in Chigh and quotient in Clow.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. Only 32 is verified.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-low reset
- start  in  1  issue request, sampled on the rising edge
- op_mul  in  1  select multiply when start is high
- op_div  in  1  select divide when start is high
- A  in  32  multiplicand / dividend, two's complement
- B  in  32  multiplier / divisor, two's complement
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: result is valid
- div_by_zero  out  1  sticky until next accepted start; high when the last DIV had B==0
- Chigh  out  32  product[63:32] or remainder
- Clow  out  32  product[31:0] or quotient

Behaviour:
- Reset (clear low, asynchronous, any state): state=IDLE; busy, done, div_by_zero, Chigh, Clow, counter and all internal registers = 0. A reset mid-operation aborts it and produces no done.
- States: IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE.
  - start while busy is ignored (no queueing, operands not re-latched).
  - If op_mul and op_div are both high, MUL wins.
  - start with neither op set is ignored.
- Edge 0 = the edge that accepts start. At edge 0:
  - latch A and B;
  - clear div_by_zero and the accumulators;
  - counter=0.
- MUL path:
  - IDLE -> MUL_RUN.
  - Radix-4 Booth bit-pair recoding of B, with implicit B[-1]=0. One digit per cycle from {-2,-1,0,+1,+2}.
  - Each cycle adds/subtracts A sign-extended to 64 bits, shifted by 2*i, for i=0..15.
  - After 16 iterations (edge 16) -> DONE.
- DIV path, B!=0:
  - IDLE -> DIV_RUN; magnitudes |A|, |B| are held as 33-bit unsigned.
  - Non-restoring division, 32 iterations: shift {R,Q} left; R = R-|B| if R>=0 else R+|B|; Q[0] = ~R[32].
  - After edge 32 -> DIV_FIX.
  - DIV_FIX (edge 33): if R<0 then R += |B|. Negate Q if A[31]^B[31]. Negate R if A[31]. Go to DONE.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - -2^31 / -1 gives Clow=0x80000000, Chigh=0, no flag.
- DIV path, B==0: at edge 0 go straight to DONE with Clow=0xFFFFFFFF, Chigh=A, div_by_zero=1.
- Latency: done is high in the cycle after edge 16 (MUL), edge 33 (DIV), or edge 0 (DIV by zero).
- busy is high in MUL_RUN, DIV_RUN and DIV_FIX; low in IDLE and DONE.
- DONE lasts one cycle, then -> IDLE, unless start is accepted in DONE (back-to-back issue allowed).
- Chigh/Clow update only on the transition into DONE and hold until the next DONE. Intermediate values never appear on them.
- Result width: 64-bit two's complement product is exact; no overflow for any 32-bit operands.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> done 17 cycles after start; Chigh=0xFFFFFFFF, Clow=0xFFFFFFEB; busy high for 16 cycles.
- MUL A=B=0x80000000 -> Chigh=0x40000000, Clow=0x00000000. Also MUL 0x7FFFFFFF*0x7FFFFFFF -> 0x3FFFFFFF_00000001.
- DIV A=-7, B=2 -> done after edge 33; Clow=0xFFFFFFFD, Chigh=0xFFFFFFFF. DIV 100/7 -> Clow=14, Chigh=2. DIV 0x80000000/-1 -> Clow=0x80000000, Chigh=0.
- DIV A=0x1234, B=0 -> done next cycle; div_by_zero=1, Clow=0xFFFFFFFF, Chigh=0x1234. A following MUL start clears div_by_zero.
- Start a MUL, pulse start with op_div at cycle 5 -> ignored; MUL result unchanged and done at cycle 17. Start issued in the DONE cycle -> accepted.
- Drop clear low at cycle 8 of a DIV -> all outputs 0 immediately; no done; the next start completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-4 Booth) and signed divide (non-restoring) engine.
// Result {Chigh, Clow}: product for MUL, {remainder, quotient} for DIV.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op_mul,
  input  logic             op_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Chigh,
  output logic [WIDTH-1:0] Clow
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mcand;
  logic [WIDTH:0]   bq;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   dvs;
  logic             a_sign;
  logic             b_sign;

  logic             accept;
  logic             take_mul;
  logic             take_div;
  logic             div_zero_now;
  logic             last_mul;
  logic             last_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [W2-1:0]    booth_term;
  logic [W2-1:0]    acc_next;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH:0]   r_fix;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  assign accept       = start & (op_mul | op_div) & ((state == IDLE) | (state == DONE));
  assign take_mul     = accept & op_mul;
  assign take_div     = accept & ~op_mul;
  assign div_zero_now = take_div & (B == '0);
  assign last_mul     = (state == MUL_RUN) && (cnt == CW'(WIDTH / 2 - 1));
  assign last_div     = (state == DIV_RUN) && (cnt == CW'(WIDTH - 1));
  assign a_mag        = A[WIDTH-1] ? -A : A;
  assign b_mag        = B[WIDTH-1] ? -B : B;

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (take_mul)          state_next = MUL_RUN;
        else if (div_zero_now) state_next = DONE;
        else if (take_div)     state_next = DIV_RUN;
        else                   state_next = IDLE;
      end
      MUL_RUN: if (last_mul) state_next = DONE;
      DIV_RUN: if (last_div) state_next = DIV_FIX;
      DIV_FIX: state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      MUL_RUN, DIV_RUN, DIV_FIX: busy = 1'b1;
      DONE:                      done = 1'b1;
      default: ;
    endcase
  end

  // Booth digit from the low three bits of the shifting multiplier {B, 0}
  always_comb begin
    booth_term = '0;
    case (bq[2:0])
      3'b001, 3'b010: booth_term = mcand;
      3'b011:         booth_term = mcand << 1;
      3'b100:         booth_term = -(mcand << 1);
      3'b101, 3'b110: booth_term = -mcand;
      default:        booth_term = '0;
    endcase
    acc_next = acc + booth_term;
  end

  always_comb begin
    r_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    r_step = rem[WIDTH] ? (r_sh + dvs) : (r_sh - dvs);
    q_step = {quo[WIDTH-2:0], ~r_step[WIDTH]};
    r_fix  = rem[WIDTH] ? (rem + dvs) : rem;
    q_out  = (a_sign ^ b_sign) ? -quo : quo;
    r_out  = a_sign ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
  end

  // Datapath: the final iteration result is written straight to the outputs
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      bq          <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      a_sign      <= 1'b0;
      b_sign      <= 1'b0;
      div_by_zero <= 1'b0;
      Chigh       <= '0;
      Clow        <= '0;
    end else if (accept) begin
      cnt         <= '0;
      acc         <= '0;
      rem         <= '0;
      mcand       <= {{WIDTH{A[WIDTH-1]}}, A};
      bq          <= {B, 1'b0};
      quo         <= a_mag;
      dvs         <= {1'b0, b_mag};
      a_sign      <= A[WIDTH-1];
      b_sign      <= B[WIDTH-1];
      div_by_zero <= div_zero_now;
      if (div_zero_now) begin
        Chigh <= A;
        Clow  <= '1;
      end
    end else begin
      case (state)
        MUL_RUN: begin
          acc   <= acc_next;
          mcand <= mcand << 2;
          bq    <= bq >> 2;
          cnt   <= cnt + CW'(1);
          if (last_mul) begin
            Chigh <= acc_next[W2-1:WIDTH];
            Clow  <= acc_next[WIDTH-1:0];
          end
        end
        DIV_RUN: begin
          rem <= r_step;
          quo <= q_step;
          cnt <= cnt + CW'(1);
        end
        DIV_FIX: begin
          rem   <= r_fix;
          Chigh <= r_out;
          Clow  <= q_out;
        end
        default: ;
      endcase
    end
  end

endmodule
